tug_war_engine: RTL
===================

Name: tug_war_engine

Overview:
- Parametrised tug-of-war game core: one human player (right) against an LFSR-driven cyber player (left), with a one-hot light on a FIELD_W-wide playfield.
- Adds multi-round match scoring (first to WIN_ROUNDS), round/match states, internal press edge detection and a configurable-width cyber LFSR.
- Sits between the board I/O wrapper (synchronised keys/switches in; LEDR/HEX drivers out) and the display decoders.

Parameters:
- FIELD_W, 9: playfield width in lights; odd, 3..31.
- LFSR_W, 10: cyber LFSR width; 8..16.
- SCORE_W, 3: score counter width.
- WIN_ROUNDS, 7: round wins needed to take the match; 1..2**SCORE_W-1.
- SERVE_DLY, 16: auto-serve delay in cycles; used only with AUTO_SERVE_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clears all state
- soft_rst  in  1  synchronous, active-high, level; starts a new round or match
- press_h  in  1  human button, already synchronised, active-high level
- cyber_thresh  in  LFSR_W  cyber aggression; 0 = never presses
- field  out  FIELD_W  one-hot light position; bit 0 = rightmost (human goal)
- score_h  out  SCORE_W  human round wins
- score_c  out  SCORE_W  cyber round wins
- round_over  out  1  high in ROUND_OVER and MATCH_OVER
- match_over  out  1  high in MATCH_OVER
- winner_h  out  1  last round won by human; valid while round_over

Behaviour:
- Reset (async): state PLAY, field = centre bit FIELD_W/2, scores 0, winner_h 0, press history 0, LFSR 0.
- Human edge: hp = press_h & ~press_h_q. Only one move per rising edge of press_h, however long it is held.
- Cyber press: cp = (cyber_thresh > lfsr), evaluated every cycle, with no edge detection.
- LFSR behaviour:
  - XNOR Fibonacci feedback, taps taken from the package table.
  - Steps every cycle in every state.
  - The all-ones lock-up state is never reached from reset.
- All outputs are registered. A move becomes visible on field one cycle after the cycle in which hp/cp is sampled high.
- State PLAY:
  - hp & ~cp: light moves right (field >> 1). If field[0] was already set: score_h++, winner_h = 1, field holds, next state ROUND_OVER.
  - cp & ~hp: light moves left (field << 1). If field[FIELD_W-1] was already set: score_c++, winner_h = 0, field holds, next state ROUND_OVER.
  - hp & cp, or neither: no change.
  - Match check: if the increment makes a score equal WIN_ROUNDS, the next state is MATCH_OVER instead of ROUND_OVER, on the same edge.
- State ROUND_OVER:
  - Presses are ignored.
  - soft_rst: field re-centred, state PLAY, scores kept.
- State MATCH_OVER:
  - Presses are ignored.
  - soft_rst: scores cleared, field re-centred, winner_h cleared, state PLAY.
- soft_rst in PLAY re-centres the field only; scores are kept.
- soft_rst has priority over a move in the same cycle.
- Scores never exceed WIN_ROUNDS; no wrap-around.
- reset mid-round or mid-match: immediate return to the reset values, independent of clk.

Optional Feature:
- Macro: TUG_WAR_AUTO_SERVE_EN.
- Defined:
  - A serve counter of width $clog2(SERVE_DLY+1) runs only in ROUND_OVER.
  - After SERVE_DLY cycles in ROUND_OVER, the engine returns to PLAY with the field re-centred, as if soft_rst had been asserted.
  - The counter clears on leaving ROUND_OVER and on reset.
  - MATCH_OVER still requires soft_rst.
- Undefined:
  - No serve counter; ROUND_OVER waits indefinitely for soft_rst.
  - SERVE_DLY is unused.

Decomposition:
- Package tug_war_pkg:
  - state enum tw_state_t {PLAY, ROUND_OVER, MATCH_OVER}.
  - Function lfsr_taps(width) returning the tap mask for widths 8..16 (e.g. 10 -> bits 9,6).
  - Constant for the centre index.
- Sub-module lfsr_gen:
  - Parameter W; ports clk, reset, q[W-1:0].
  - Instantiated once for the cyber player.

Test Plan:
- Reset then release, cyber_thresh = 10'h3FF, press_h = 0 -> field walks left from bit 4 to bit 8. On the next cp, score_c = 1, round_over = 1, winner_h = 0, and field stays at 9'b100000000.
- cyber_thresh = 0, soft_rst pulse, 5 separate press_h pulses -> field walks 4 -> 0 and score_h = 1 on the 5th pulse. A press_h held high for 20 cycles moves the light exactly once.
- cyber_thresh = 0, 7 rounds won by human with soft_rst between rounds -> match_over = 1 and score_h = 7. Further presses give no change; soft_rst -> scores 0, field 9'b000010000.
- press_h edge in the same cycle as cp = 1 -> field unchanged. soft_rst in the same cycle as a winning press -> field centred and score unchanged.
- reset asserted mid-round, asynchronously between clock edges -> all outputs at reset values before the next posedge.
- With TUG_WAR_AUTO_SERVE_EN defined and SERVE_DLY = 16: round win -> round_over stays high for 16 cycles, then returns to PLAY with field centred.

Source files
------------

// File: rtl/tug_war_pkg.sv
// Shared types and helpers for the tug-of-war engine.
// Contents:
//   tw_state_t  - round/match FSM state
//   lfsr_taps() - XNOR Fibonacci tap mask for LFSR widths 8..16
//   tw_centre() - centre light index for a playfield width
package tug_war_pkg;

  typedef enum logic [1:0] {
    PLAY       = 2'd0,
    ROUND_OVER = 2'd1,
    MATCH_OVER = 2'd2
  } tw_state_t;

  // Centre light of the default 9-wide field.
  localparam int TW_DEF_FIELD_W = 9;
  localparam int TW_DEF_CENTRE  = TW_DEF_FIELD_W / 2;

  function automatic int tw_centre(input int width);
    return width / 2;
  endfunction

  // Tap masks, bit positions 0-based (e.g. width 10 -> bits 9 and 6).
  function automatic logic [15:0] lfsr_taps(input int width);
    case (width)
      8:       return 16'h00B8;  // 7,5,4,3
      9:       return 16'h0110;  // 8,4
      10:      return 16'h0240;  // 9,6
      11:      return 16'h0500;  // 10,8
      12:      return 16'h0829;  // 11,5,3,0
      13:      return 16'h100D;  // 12,3,2,0
      14:      return 16'h2015;  // 13,4,2,0
      15:      return 16'h6000;  // 14,13
      16:      return 16'hD008;  // 15,14,12,3
      default: return 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/tug_war_engine_lfsr.sv
// XNOR Fibonacci LFSR used as the cyber player's random source.
// Resets to 0; with XNOR feedback the all-ones state is a fixed point
// whose only predecessor is itself, so it is never entered from reset.
// Ports:
//   clk   - clock
//   reset - async active-high reset, clears q
//   q     - current LFSR state, steps every cycle
module lfsr_gen
  import tug_war_pkg::*;
#(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  output logic [W-1:0] q
);

  localparam logic [15:0]  TAPS_FULL = lfsr_taps(W);
  localparam logic [W-1:0] TAPS      = TAPS_FULL[W-1:0];

  logic [W-1:0] r_q;
  logic         w_fb;

  assign w_fb = ~^(r_q & TAPS);
  assign q    = r_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_q <= '0;
    else       r_q <= {r_q[W-2:0], w_fb};
  end

endmodule

// File: rtl/tug_war_engine.sv
// Tug-of-war game core: human player (right, goal at bit 0) against an
// LFSR-driven cyber player (left, goal at bit FIELD_W-1). A one-hot light
// moves one step per accepted press; pushing it past an end scores a round,
// and the first to WIN_ROUNDS round wins takes the match.
// Optional build macro: TUG_WAR_AUTO_SERVE_EN - when defined, ROUND_OVER
// returns to PLAY by itself after SERVE_DLY cycles.
// Ports:
//   clk, reset    - clock, async active-high reset
//   soft_rst      - sync level: re-centre / next round / new match
//   press_h       - human button (synchronised level), edge-detected here
//   cyber_thresh  - cyber presses whenever thresh > LFSR; 0 = never
//   field         - one-hot light position
//   score_h/c     - round wins, human / cyber
//   round_over    - high in ROUND_OVER and MATCH_OVER
//   match_over    - high in MATCH_OVER
//   winner_h      - last round won by human
module tug_war_engine
  import tug_war_pkg::*;
#(
  parameter int FIELD_W    = 9,
  parameter int LFSR_W     = 10,
  parameter int SCORE_W    = 3,
  parameter int WIN_ROUNDS = 7,
  parameter int SERVE_DLY  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               soft_rst,
  input  logic               press_h,
  input  logic [LFSR_W-1:0]  cyber_thresh,
  output logic [FIELD_W-1:0] field,
  output logic [SCORE_W-1:0] score_h,
  output logic [SCORE_W-1:0] score_c,
  output logic               round_over,
  output logic               match_over,
  output logic               winner_h
);

  localparam logic [FIELD_W-1:0] CENTRE_1H = FIELD_W'(1) << tw_centre(FIELD_W);
  localparam logic [SCORE_W-1:0] LAST_WIN  = SCORE_W'(WIN_ROUNDS - 1);

  tw_state_t          r_state;
  logic [FIELD_W-1:0] r_field;
  logic [SCORE_W-1:0] r_score_h;
  logic [SCORE_W-1:0] r_score_c;
  logic               r_round_over;
  logic               r_match_over;
  logic               r_winner_h;
  logic               r_press_q;

  logic [LFSR_W-1:0]  w_lfsr;
  logic               w_hp;
  logic               w_cp;
  logic               w_serve_done;

  lfsr_gen #(.W(LFSR_W)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (w_lfsr)
  );

  assign w_hp = press_h & ~r_press_q;
  assign w_cp = (cyber_thresh > w_lfsr);

`ifdef TUG_WAR_AUTO_SERVE_EN
  localparam int SRV_W = $clog2(SERVE_DLY + 1);

  logic [SRV_W-1:0] r_serve_cnt;

  // Counts ROUND_OVER cycles; done on the last one so the state spends
  // exactly SERVE_DLY cycles there.
  assign w_serve_done = (r_state == ROUND_OVER) &&
                        (r_serve_cnt == SRV_W'(SERVE_DLY - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_serve_cnt <= '0;
    else if (r_state == ROUND_OVER && !soft_rst && !w_serve_done)
      r_serve_cnt <= r_serve_cnt + SRV_W'(1);
    else
      r_serve_cnt <= '0;
  end
`else
  // No auto-serve: ROUND_OVER waits for soft_rst. The term keeps SERVE_DLY
  // referenced without affecting logic.
  assign w_serve_done = 1'b0 & (SERVE_DLY == 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= PLAY;
      r_field      <= CENTRE_1H;
      r_score_h    <= '0;
      r_score_c    <= '0;
      r_round_over <= 1'b0;
      r_match_over <= 1'b0;
      r_winner_h   <= 1'b0;
      r_press_q    <= 1'b0;
    end else begin
      r_press_q <= press_h;
      case (r_state)
        PLAY: begin
          if (soft_rst) begin
            r_field <= CENTRE_1H;
          end else if (w_hp && !w_cp) begin
            if (r_field[0]) begin
              r_score_h    <= r_score_h + SCORE_W'(1);
              r_winner_h   <= 1'b1;
              r_round_over <= 1'b1;
              if (r_score_h == LAST_WIN) begin
                r_state      <= MATCH_OVER;
                r_match_over <= 1'b1;
              end else begin
                r_state <= ROUND_OVER;
              end
            end else begin
              r_field <= r_field >> 1;
            end
          end else if (w_cp && !w_hp) begin
            if (r_field[FIELD_W-1]) begin
              r_score_c    <= r_score_c + SCORE_W'(1);
              r_winner_h   <= 1'b0;
              r_round_over <= 1'b1;
              if (r_score_c == LAST_WIN) begin
                r_state      <= MATCH_OVER;
                r_match_over <= 1'b1;
              end else begin
                r_state <= ROUND_OVER;
              end
            end else begin
              r_field <= r_field << 1;
            end
          end
        end
        ROUND_OVER: begin
          if (soft_rst || w_serve_done) begin
            r_field      <= CENTRE_1H;
            r_state      <= PLAY;
            r_round_over <= 1'b0;
          end
        end
        MATCH_OVER: begin
          if (soft_rst) begin
            r_field      <= CENTRE_1H;
            r_score_h    <= '0;
            r_score_c    <= '0;
            r_winner_h   <= 1'b0;
            r_state      <= PLAY;
            r_round_over <= 1'b0;
            r_match_over <= 1'b0;
          end
        end
        default: begin
          r_state      <= PLAY;
          r_field      <= CENTRE_1H;
          r_round_over <= 1'b0;
          r_match_over <= 1'b0;
        end
      endcase
    end
  end

  assign field      = r_field;
  assign score_h    = r_score_h;
  assign score_c    = r_score_c;
  assign round_over = r_round_over;
  assign match_over = r_match_over;
  assign winner_h   = r_winner_h;

endmodule
